// File: rtl/rf_multiport.sv
// -----------------------------------------------------------------------------
// rf_multiport
//   2^ADDR_W x DATA_W general-purpose register file with NUM_RD combinational
//   read ports, one synchronous write port and a per-register pending-write
//   scoreboard. After reset a sweep FSM clears one entry per cycle so the
//   array has a single write port and can map onto RAM.
//
//   Optional feature macro: RF_BYPASS_EN
//     defined   -> a read of the register being written this cycle returns wd
//                  with rd_busy=0 (write-through bypass)
//     undefined -> reads see only the array and the registered busy bits
//
// Parameters
//   DATA_W  register width in bits
//   ADDR_W  register address width, depth = 2^ADDR_W
//   NUM_RD  number of read ports (>= 1)
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-high
//   rd_addr    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data    read data,      port k at [k*DATA_W +: DATA_W]
//   rd_busy    per port: addressed register has a pending write
//   we/wa/wd   writeback write port
//   iss_valid  an instruction with destination iss_addr issues this cycle
//   iss_addr   destination register being issued
//   ready      clearing sweep complete, file usable
// -----------------------------------------------------------------------------
module rf_multiport #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     ready
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e              state_q;
    logic [ADDR_W:0]     cnt_q;
    logic                ready_q;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]    busy_q;
    logic [DEPTH-1:0]    busy_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic [ADDR_W-1:0]   rd_a [NUM_RD];

    // ------------------------------------------------------------------
    // Sweep FSM: CLEAR walks cnt over every entry, then parks in READY.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == (ADDR_W + 1)'(DEPTH - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    state_q <= READY;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_q;

    // ------------------------------------------------------------------
    // Single array write port shared by the sweep and writeback, so the
    // array needs no reset and no second port.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we = 1'b0;
        mem_wa = wa;
        mem_wd = wd;
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_we = 1'b1;
                mem_wa = cnt_q[ADDR_W-1:0];
                mem_wd = '0;
            end else if (we && (wa != '0)) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: issue sets, writeback clears, issue wins on a collision
    // because the written value belongs to the older producer.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (state_q == READY) begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (iss_valid && (iss_addr == ADDR_W'(r))) begin
                    busy_d[r] = 1'b1;
                end else if (we && (wa == ADDR_W'(r))) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports.
    // ------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_a[k] = rd_addr[k*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if ((state_q == READY) && (rd_a[k] != '0)) begin
                rd_data[k*DATA_W +: DATA_W] = mem_q[rd_a[k]];
                rd_busy[k]                  = busy_q[rd_a[k]];
`ifdef RF_BYPASS_EN
                if (we && (wa == rd_a[k])) begin
                    rd_data[k*DATA_W +: DATA_W] = wd;
                    rd_busy[k]                  = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// -----------------------------------------------------------------------------
// tb_rf_multiport
//   Directed self-checking bench for rf_multiport. Instance u_dut uses the
//   default 32/5/2 configuration, u_dut2 the 16/3/3 configuration; both share
//   clk and reset.
// -----------------------------------------------------------------------------
module tb_rf_multiport;

    logic        clk;
    logic        reset;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        ready;

    logic [8:0]  rd_addr2;
    logic [47:0] rd_data2;
    logic [2:0]  rd_busy2;
    logic        we2;
    logic [2:0]  wa2;
    logic [15:0] wd2;
    logic        iss_valid2;
    logic [2:0]  iss_addr2;
    logic        ready2;

    int checks;
    int errors;

    rf_multiport #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .ready     (ready)
    );

    rf_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr2),
        .rd_data   (rd_data2),
        .rd_busy   (rd_busy2),
        .we        (we2),
        .wa        (wa2),
        .wd        (wd2),
        .iss_valid (iss_valid2),
        .iss_addr  (iss_addr2),
        .ready     (ready2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rd_addr  = {5'd7, 5'd3};
        rd_addr2 = {3'd7, 3'd2, 3'd1};
        repeat (3) step();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %0b want 0", ready);
        end
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reset_outputs got data %h busy %b want 0/00", rd_data, rd_busy);
        end
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++;
            if (ready !== (i == 32)) begin
                errors++;
                $display("FAIL sweep_ready edge %0d got %0b want %0b", i, ready, (i == 32));
            end
            checks++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                errors++;
                $display("FAIL sweep_read edge %0d got data %h busy %b want 0/00", i, rd_data, rd_busy);
            end
            checks++;
            if (ready2 !== (i >= 8)) begin
                errors++;
                $display("FAIL sweep_ready2 edge %0d got %0b want %0b", i, ready2, (i >= 8));
            end
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 5'd5; wd = 32'h12345678;
        step();
        we = 1'b0;
        rd_addr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rd_data[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL write_read got %h want 12345678", rd_data[31:0]);
        end
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rd_data[63:32] !== 32'h0 || rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL reg0_read got %h busy %b want 0/0", rd_data[63:32], rd_busy[1]);
        end
        checks++;
        if (rd_data[31:0] !== 32'h12345678) begin
            errors++;
            $display("FAIL reg5_keep got %h want 12345678", rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd0, 5'd8};
        iss_valid = 1'b1; iss_addr = 5'd8;
        step();
        iss_valid = 1'b0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL issue_busy got %b want 1", rd_busy[0]);
        end
        step();
        we = 1'b1; wa = 5'd8; wd = 32'hA5A5A5A5;
        #1;
        checks++;
`ifdef RF_BYPASS_EN
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wb_cycle got %h busy %b want a5a5a5a5/0", rd_data[31:0], rd_busy[0]);
        end
`else
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL wb_cycle got %h busy %b want 0/1", rd_data[31:0], rd_busy[0]);
        end
`endif
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL wb_clear got %h busy %b want a5a5a5a5/0", rd_data[31:0], rd_busy[0]);
        end
        iss_valid = 1'b1; iss_addr = 5'd8;
        we = 1'b1; wa = 5'd8; wd = 32'h00000011;
        step();
        iss_valid = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h00000011) begin
            errors++;
            $display("FAIL issue_wins got %h busy %b want 00000011/1", rd_data[31:0], rd_busy[0]);
        end
        iss_valid = 1'b1; iss_addr = 5'd0;
        step();
        iss_valid = 1'b0;
        rd_addr = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL reg0_busy got %b want 00", rd_busy);
        end
    endtask

    task automatic test_bypass();
        iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        iss_valid = 1'b0;
        rd_addr = {5'd9, 5'd9};
        we = 1'b1; wa = 5'd9; wd = 32'hCAFEF00D;
        #1;
        checks++;
`ifdef RF_BYPASS_EN
        if (rd_data !== {2{32'hCAFEF00D}} || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL bypass got %h busy %b want cafef00d x2 / 00", rd_data, rd_busy);
        end
`else
        if (rd_data !== 64'h0 || rd_busy !== 2'b11) begin
            errors++;
            $display("FAIL bypass got %h busy %b want 0 / 11", rd_data, rd_busy);
        end
`endif
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rd_data !== {2{32'hCAFEF00D}} || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL bypass_after got %h busy %b want cafef00d x2 / 00", rd_data, rd_busy);
        end
    endtask

    task automatic test_independent();
        iss_valid = 1'b1; iss_addr = 5'd10;
        we = 1'b1; wa = 5'd11; wd = 32'h0BADBEEF;
        step();
        iss_valid = 1'b0; we = 1'b0;
        rd_addr = {5'd11, 5'd10};
        #1;
        checks++;
        if (rd_busy !== 2'b01 || rd_data[63:32] !== 32'h0BADBEEF || rd_data[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL independent got %h busy %b want 0badbeef_00000000 / 01", rd_data, rd_busy);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        for (int r = 1; r <= 4; r++) begin
            we = 1'b1; wa = 5'(r); wd = 32'h100 + 32'(r);
            step();
        end
        we = 1'b0;
        iss_valid = 1'b1; iss_addr = 5'd4;
        step();
        iss_valid = 1'b0;
        rd_addr = {5'd4, 5'd1};
        #1;
        checks++;
        if (rd_data !== {32'h104, 32'h101} || rd_busy !== 2'b10) begin
            errors++;
            $display("FAIL populate got %h busy %b want 104_101 / 10", rd_data, rd_busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        we = 1'b1; wa = 5'd3; wd = 32'hDEADDEAD;
        iss_valid = 1'b1; iss_addr = 5'd3;
        #1;
        checks++;
        if (ready !== 1'b0 || rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset got ready %b data %h busy %b want 0/0/00", ready, rd_data, rd_busy);
        end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        we = 1'b0; iss_valid = 1'b0;
        #1;
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL resweep_len got %0d edges want 32", n);
        end
        rd_addr = {5'd2, 5'd1};
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL cleared_1_2 got %h busy %b want 0/00", rd_data, rd_busy);
        end
        rd_addr = {5'd4, 5'd3};
        #1;
        checks++;
        if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
            errors++;
            $display("FAIL cleared_3_4 got %h busy %b want 0/00", rd_data, rd_busy);
        end
    endtask

    task automatic test_param();
        we2 = 1'b1; wa2 = 3'd3; wd2 = 16'hBEEF;
        step();
        wa2 = 3'd5; wd2 = 16'h1234;
        step();
        wa2 = 3'd7; wd2 = 16'hFFFF;
        iss_valid2 = 1'b1; iss_addr2 = 3'd6;
        step();
        we2 = 1'b0; iss_valid2 = 1'b0;
        rd_addr2 = {3'd7, 3'd3, 3'd5};
        #1;
        checks++;
        if (rd_data2 !== {16'hFFFF, 16'hBEEF, 16'h1234} || rd_busy2 !== 3'b000) begin
            errors++;
            $display("FAIL p3_distinct got %h busy %b want ffff_beef_1234 / 000", rd_data2, rd_busy2);
        end
        rd_addr2 = {3'd3, 3'd3, 3'd3};
        #1;
        checks++;
        if (rd_data2 !== {3{16'hBEEF}}) begin
            errors++;
            $display("FAIL p3_same got %h want beef x3", rd_data2);
        end
        rd_addr2 = {3'd6, 3'd0, 3'd6};
        #1;
        checks++;
        if (rd_data2 !== 48'h0 || rd_busy2 !== 3'b101) begin
            errors++;
            $display("FAIL p3_busy got %h busy %b want 0 / 101", rd_data2, rd_busy2);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        rd_addr    = '0;
        we         = 1'b0;
        wa         = '0;
        wd         = '0;
        iss_valid  = 1'b0;
        iss_addr   = '0;
        rd_addr2   = '0;
        we2        = 1'b0;
        wa2        = '0;
        wd2        = '0;
        iss_valid2 = 1'b0;
        iss_addr2  = '0;

        test_reset();
        test_write_read();
        test_scoreboard();
        test_bypass();
        test_independent();
        test_reset_mid();
        test_param();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
